// File: rtl/soc_system_sysid_ext.sv
// System identification slave: ID and build timestamp words, 64-bit free-running uptime,
// a byte-writable scratch register and a capability word, all read through a fixed-latency pipeline.
module soc_system_sysid_ext #(
    parameter logic [31:0] ID_VALUE      = 32'hACD51302,
    parameter logic [31:0] TIMESTAMP     = 32'h57117CE3,
    parameter int          READ_LATENCY  = 1,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd4;
    localparam logic [2:0] ADDR_CAPS      = 3'd5;

    localparam logic [31:0] CAPS_VALUE = {16'h0000, 8'd6, 8'(READ_LATENCY)};

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("soc_system_sysid_ext: READ_LATENCY must be in 1..4");
        end
    endgenerate

    logic [63:0] uptime;
    logic [31:0] shadow_hi;
    logic [31:0] scratch;
    logic [31:0] rd_mux;

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [31:0]             pipe_dat [READ_LATENCY];

    // Read value as it stands at the accepting edge; scratch is pre-write here.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:        rd_mux = ID_VALUE;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_UPTIME_LO: rd_mux = uptime[31:0];
            ADDR_UPTIME_HI: rd_mux = shadow_hi;
            ADDR_SCRATCH:   rd_mux = scratch;
            ADDR_CAPS:      rd_mux = CAPS_VALUE;
            default:        rd_mux = '0;
        endcase
    end

    // Reading LO latches the upper half so the following HI read is coherent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uptime    <= '0;
            shadow_hi <= '0;
        end else begin
            uptime <= uptime + 64'd1;
            if (read && address == ADDR_UPTIME_LO) begin
                shadow_hi <= uptime[63:32];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch <= SCRATCH_RESET;
        end else if (write && address == ADDR_SCRATCH) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    scratch[8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    // Idle stages carry zero data so readdata is 0 whenever readdatavalid is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= read;
            pipe_dat[0] <= read ? rd_mux : 32'h0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign readdata      = pipe_dat[READ_LATENCY-1];
    assign readdatavalid = pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// Bench for soc_system_sysid_ext: three instances (latency 1, 3, 4) share one stimulus stream and
// are compared every cycle against a register-map model with a per-edge read history.
module tb_soc_system_sysid_ext;

    localparam logic [31:0] ID_VALUE  = 32'hACD51302;
    localparam logic [31:0] TIMESTAMP = 32'h57117CE3;
    localparam logic [31:0] SCR_RST   = 32'hC0DE_0042;
    localparam int          LAT [3]   = '{1, 3, 4};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic [31:0] rd1, rd3, rd4;
    logic        rv1, rv3, rv4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    soc_system_sysid_ext #(.READ_LATENCY(1), .SCRATCH_RESET(SCR_RST)) u1 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd1), .readdatavalid(rv1));
    soc_system_sysid_ext #(.READ_LATENCY(3), .SCRATCH_RESET(SCR_RST)) u3 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd3), .readdatavalid(rv3));
    soc_system_sysid_ext #(.READ_LATENCY(4), .SCRATCH_RESET(SCR_RST)) u4 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd4), .readdatavalid(rv4));

    // Reference model: architectural register state plus the reads accepted at each recent edge.
    logic [63:0] m_up;
    logic [31:0] m_shadow;
    logic [31:0] m_scratch;
    int          k = 8;
    logic        h_v [8];
    logic [2:0]  h_a [8];
    logic [31:0] h_d [8];
    logic        e_v [3];
    logic [31:0] e_d [3];
    logic        obs_v [3];
    logic [31:0] obs_d [3];

    function automatic logic [31:0] caps_word(input int lat);
        return {16'h0000, 8'd6, 8'(lat)};
    endfunction

    function automatic logic [31:0] reg_value(input logic [2:0] a);
        case (a)
            3'd0:    return ID_VALUE;
            3'd1:    return TIMESTAMP;
            3'd2:    return m_up[31:0];
            3'd3:    return m_shadow;
            3'd4:    return m_scratch;
            default: return 32'h0;
        endcase
    endfunction

    task automatic sample();
        int j;
        for (int i = 0; i < 3; i++) begin
            j = k - LAT[i] + 1;
            e_v[i] = h_v[j % 8];
            if (!e_v[i])              e_d[i] = 32'h0;
            else if (h_a[j % 8] == 5) e_d[i] = caps_word(LAT[i]);
            else                      e_d[i] = h_d[j % 8];
        end
        obs_v[0] = rv1; obs_v[1] = rv3; obs_v[2] = rv4;
        obs_d[0] = rd1; obs_d[1] = rd3; obs_d[2] = rd4;
    endtask

    task automatic step(input logic r, input logic w, input logic [2:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] v;
        read = r; write = w; address = a; writedata = wd; byteenable = be;
        v = reg_value(a);
        @(posedge clock);
        k++;
        h_v[k % 8] = r && !reset;
        h_a[k % 8] = a;
        h_d[k % 8] = v;
        if (!reset) begin
            if (r && a == 3'd2) m_shadow = m_up[63:32];
            if (w && a == 3'd4) begin
                for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
            end
            m_up = m_up + 64'd1;
        end
        #1;
        read = 1'b0; write = 1'b0;
        sample();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        m_up = 64'h0; m_shadow = 32'h0; m_scratch = SCR_RST;
        foreach (h_v[i]) h_v[i] = 1'b0;
        #1;
        sample();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs_v[i] !== 1'b0 || obs_d[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs lat=%0d: got vld=%0b data=%h, want vld=0 data=0", LAT[i], obs_v[i], obs_d[i]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF, 4'hF);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_v[i] !== e_v[i] || obs_d[i] !== e_d[i]) begin
                    n_fail++;
                    $display("FAIL reset_ignores_access lat=%0d: got vld=%0b data=%h, want vld=%0b data=%h", LAT[i], obs_v[i], obs_d[i], e_v[i], e_d[i]);
                end
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      step(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
            else if (c == 1) step(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
            else             step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_v[i] !== e_v[i] || obs_d[i] !== e_d[i]) begin
                    n_fail++;
                    $display("FAIL post_reset lat=%0d: got vld=%0b data=%h, want vld=%0b data=%h", LAT[i], obs_v[i], obs_d[i], e_v[i], e_d[i]);
                end
            end
            if (c < 2) begin
                n_checks++;
                if ({rv1, rd1} !== {1'b1, (c == 0) ? SCR_RST : 32'd1}) begin
                    n_fail++;
                    $display("FAIL post_reset_value step=%0d: got vld=%0b data=%h, want vld=1 data=%h", c, rv1, rd1, (c == 0) ? SCR_RST : 32'd1);
                end
            end
        end
    endtask

    task automatic test_id_ts();
        logic [32:0] want;
        for (int c = 0; c < 6; c++) begin
            if (c < 2) step(1'b1, 1'b0, 3'(c), 32'h0, 4'h0);
            else       step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_v[i] !== e_v[i] || obs_d[i] !== e_d[i]) begin
                    n_fail++;
                    $display("FAIL id_ts lat=%0d: got vld=%0b data=%h, want vld=%0b data=%h", LAT[i], obs_v[i], obs_d[i], e_v[i], e_d[i]);
                end
            end
            want = (c == 0) ? {1'b1, ID_VALUE} : (c == 1) ? {1'b1, TIMESTAMP} : 33'h0;
            n_checks++;
            if ({rv1, rd1} !== want) begin
                n_fail++;
                $display("FAIL id_ts_lat1 step=%0d: got %h, want %h", c, {rv1, rd1}, want);
            end
        end
    endtask

    task automatic test_caps();
        logic [32:0] want;
        for (int c = 0; c < 6; c++) begin
            step(c == 0, 1'b0, 3'd5, 32'h0, 4'h0);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_v[i] !== e_v[i] || obs_d[i] !== e_d[i]) begin
                    n_fail++;
                    $display("FAIL caps lat=%0d: got vld=%0b data=%h, want vld=%0b data=%h", LAT[i], obs_v[i], obs_d[i], e_v[i], e_d[i]);
                end
            end
            want = (c == 2) ? {1'b1, 32'h0000_0603} : 33'h0;
            n_checks++;
            if ({rv3, rd3} !== want) begin
                n_fail++;
                $display("FAIL caps_lat3 step=%0d: got %h, want %h", c, {rv3, rd3}, want);
            end
        end
    endtask

    task automatic test_scratch();
        logic        s_r  [8] = '{0, 0, 1, 1, 1, 0, 1, 0};
        logic        s_w  [8] = '{1, 1, 0, 1, 0, 1, 0, 0};
        logic [31:0] s_d  [8] = '{32'hDEADBEEF, 32'h1234_5678, 0, 32'hAAAA_5555, 0, 32'h0, 0, 0};
        logic [3:0]  s_be [8] = '{4'hF, 4'h5, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [32:0] want [8] = '{33'h0, 33'h0, {1'b1, 32'hDE34BE78}, {1'b1, 32'hDE34BE78},
                                  {1'b1, 32'hAAAA5555}, 33'h0, {1'b1, 32'hAAAA5555}, 33'h0};
        for (int c = 0; c < 8; c++) begin
            step(s_r[c], s_w[c], 3'd4, s_d[c], s_be[c]);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_v[i] !== e_v[i] || obs_d[i] !== e_d[i]) begin
                    n_fail++;
                    $display("FAIL scratch lat=%0d: got vld=%0b data=%h, want vld=%0b data=%h", LAT[i], obs_v[i], obs_d[i], e_v[i], e_d[i]);
                end
            end
            n_checks++;
            if ({rv1, rd1} !== want[c]) begin
                n_fail++;
                $display("FAIL scratch_lat1 step=%0d: got %h, want %h", c, {rv1, rd1}, want[c]);
            end
        end
    endtask

    task automatic test_ro_writes();
        logic        s_r  [7] = '{0, 0, 1, 1, 1, 1, 0};
        logic        s_w  [7] = '{1, 1, 0, 0, 0, 1, 0};
        logic [2:0]  s_a  [7] = '{3'd0, 3'd7, 3'd0, 3'd7, 3'd4, 3'd1, 3'd0};
        logic [32:0] want [7] = '{33'h0, 33'h0, {1'b1, ID_VALUE}, {1'b1, 32'h0},
                                  {1'b1, 32'hAAAA5555}, {1'b1, TIMESTAMP}, 33'h0};
        for (int c = 0; c < 7; c++) begin
            step(s_r[c], s_w[c], s_a[c], 32'hFFFF_FFFF, 4'hF);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_v[i] !== e_v[i] || obs_d[i] !== e_d[i]) begin
                    n_fail++;
                    $display("FAIL ro_writes lat=%0d: got vld=%0b data=%h, want vld=%0b data=%h", LAT[i], obs_v[i], obs_d[i], e_v[i], e_d[i]);
                end
            end
            n_checks++;
            if ({rv1, rd1} !== want[c]) begin
                n_fail++;
                $display("FAIL ro_writes_lat1 step=%0d: got %h, want %h", c, {rv1, rd1}, want[c]);
            end
        end
    endtask

    task automatic test_uptime_carry();
        logic [32:0] want;
        force u1.uptime = 64'h0000_0000_FFFF_FFFE;
        force u3.uptime = 64'h0000_0000_FFFF_FFFE;
        force u4.uptime = 64'h0000_0000_FFFF_FFFE;
        #1;
        release u1.uptime;
        release u3.uptime;
        release u4.uptime;
        m_up = 64'h0000_0000_FFFF_FFFE;
        for (int c = 0; c < 12; c++) begin
            if (c == 0 || c == 8)      step(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
            else if (c == 6 || c == 9) step(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
            else                       step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_v[i] !== e_v[i] || obs_d[i] !== e_d[i]) begin
                    n_fail++;
                    $display("FAIL uptime lat=%0d: got vld=%0b data=%h, want vld=%0b data=%h", LAT[i], obs_v[i], obs_d[i], e_v[i], e_d[i]);
                end
            end
            case (c)
                0:       want = {1'b1, 32'hFFFF_FFFE};
                6:       want = {1'b1, 32'h0000_0000};
                8:       want = {1'b1, 32'h0000_0006};
                9:       want = {1'b1, 32'h0000_0001};
                default: want = 33'h0;
            endcase
            n_checks++;
            if ({rv1, rd1} !== want) begin
                n_fail++;
                $display("FAIL uptime_carry_lat1 step=%0d: got %h, want %h", c, {rv1, rd1}, want);
            end
        end
    endtask

    task automatic test_random();
        logic       r, w;
        logic [2:0] a;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 9) < 6);
            w = ($urandom_range(0, 9) < 4);
            a = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'($urandom_range(0, 7));
            step(r, w, a, $urandom, 4'($urandom_range(0, 15)));
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_v[i] !== e_v[i] || obs_d[i] !== e_d[i]) begin
                    n_fail++;
                    $display("FAIL random c=%0d lat=%0d: got vld=%0b data=%h, want vld=%0b data=%h", c, LAT[i], obs_v[i], obs_d[i], e_v[i], e_d[i]);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, (c == 2) ? 3'd4 : 3'(c * 2), 32'h5555_AAAA, 4'hF);
        end
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            if (c == 3) reset = 1'b0;
            if (c == 3)      step(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
            else if (c == 4) step(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
            else             step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_v[i] !== e_v[i] || obs_d[i] !== e_d[i]) begin
                    n_fail++;
                    $display("FAIL reset_inflight lat=%0d: got vld=%0b data=%h, want vld=%0b data=%h", LAT[i], obs_v[i], obs_d[i], e_v[i], e_d[i]);
                end
            end
            if (c < 6) begin
                n_checks++;
                if (rv4 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_inflight_lat4 step=%0d: got vld=%0b, want vld=0", c, rv4);
                end
            end
            if (c == 3 || c == 4) begin
                n_checks++;
                if ({rv1, rd1} !== {1'b1, (c == 3) ? SCR_RST : 32'd1}) begin
                    n_fail++;
                    $display("FAIL reset_inflight_restart step=%0d: got vld=%0b data=%h, want vld=1 data=%h", c, rv1, rd1, (c == 3) ? SCR_RST : 32'd1);
                end
            end
        end
    endtask

    initial begin
        m_up = 64'h0; m_shadow = 32'h0; m_scratch = SCR_RST;
        foreach (h_v[i]) begin
            h_v[i] = 1'b0; h_a[i] = 3'd0; h_d[i] = 32'h0;
        end
        #1;
        test_reset();
        test_id_ts();
        test_caps();
        test_scratch();
        test_ro_writes();
        test_uptime_carry();
        test_random();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
